// File: rtl/pc_ctrl_if.sv
// Bus between the core and the program-counter unit: flow-control inputs in, PC/RAS state out.
interface pc_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic [2:0]        npc_sel;
    logic [2:0]        br_type;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic [25:0]       imm26;
    logic [31:0]       ext;
    logic [ADDR_W-1:0] ra;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] npc;
    logic              br_taken;
    logic              misalign;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ret_mispred;

    // Core side: drives control and operands, observes the PC unit.
    modport master (
        output stall, npc_sel, br_type, rs_val, rt_val, imm26, ext, ra,
        input  pc, pc4, npc, br_taken, misalign, ras_top, ras_empty, ret_mispred
    );

    // PC unit side.
    modport slave (
        input  stall, npc_sel, br_type, rs_val, rt_val, imm26, ext, ra,
        output pc, pc4, npc, br_taken, misalign, ras_top, ras_empty, ret_mispred
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter unit: PC register, next-PC selection, branch evaluation and a
// circular return-address stack that predicts `jr $31` targets.
// Optional macro PC_CTRL_RAS_STATS_EN adds saturating ret / ret-miss counters.
module pc_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_3000),
    parameter int unsigned       RAS_DEPTH = 4,
    parameter int unsigned       RAS_PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    pc_ctrl_if.slave    bus
`ifdef PC_CTRL_RAS_STATS_EN
    ,
    output logic [31:0] ret_cnt,
    output logic [31:0] ret_miss_cnt
`endif
);
    localparam int unsigned CNT_W = RAS_PTR_W + 1;

    localparam logic [2:0] SEL_BR   = 3'b001;
    localparam logic [2:0] SEL_J    = 3'b010;
    localparam logic [2:0] SEL_JAL  = 3'b011;
    localparam logic [2:0] SEL_JR   = 3'b100;
    localparam logic [2:0] SEL_RET  = 3'b101;
    localparam logic [2:0] SEL_JALR = 3'b110;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0]  ras_cnt;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] top;
    logic              cond;
    logic              rs_zero;
    logic              rs_neg;
    logic              empty;
    logic              mispred;
    logic              push;
    logic              pop;

    assign pc4     = pc_q + ADDR_W'(4);
    assign br_off  = ADDR_W'({{ADDR_W{bus.ext[31]}}, bus.ext} << 2);
    assign rs_zero = (bus.rs_val == 32'd0);
    assign rs_neg  = bus.rs_val[31];

    // Branch condition for the selected br_type; unknown encodings never take.
    always_comb begin
        cond = 1'b0;
        case (bus.br_type)
            3'b000:  cond = (bus.rs_val == bus.rt_val);
            3'b001:  cond = (bus.rs_val != bus.rt_val);
            3'b010:  cond = rs_neg | rs_zero;
            3'b011:  cond = ~rs_neg & ~rs_zero;
            3'b100:  cond = rs_neg;
            3'b101:  cond = ~rs_neg;
            default: cond = 1'b0;
        endcase
    end

    // Next-PC select; register targets always come from ra, the RAS only predicts.
    always_comb begin
        npc           = pc4;
        jmp_tgt       = pc_q;
        jmp_tgt[27:0] = {bus.imm26, 2'b00};
        case (bus.npc_sel)
            SEL_BR:                   npc = cond ? (pc4 + br_off) : pc4;
            SEL_J, SEL_JAL:           npc = jmp_tgt;
            SEL_JR, SEL_RET, SEL_JALR: npc = bus.ra;
            default:                  npc = pc4;
        endcase
    end

    assign empty   = (ras_cnt == CNT_W'(0));
    assign top     = empty ? '0 : ras_mem[ras_ptr - RAS_PTR_W'(1)];
    assign mispred = (bus.npc_sel == SEL_RET) && (empty || (top != bus.ra));
    assign push    = ~bus.stall && ((bus.npc_sel == SEL_JAL) || (bus.npc_sel == SEL_JALR));
    assign pop     = ~bus.stall && (bus.npc_sel == SEL_RET) && ~empty;

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.npc         = npc;
    assign bus.br_taken    = cond && (bus.npc_sel == SEL_BR);
    assign bus.misalign    = |npc[1:0];
    assign bus.ras_top     = top;
    assign bus.ras_empty   = empty;
    assign bus.ret_mispred = mispred;

    // PC register and RAS state; a full push overwrites the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!bus.stall) begin
            pc_q <= npc;
            if (push) begin
                ras_mem[ras_ptr] <= pc4;
                ras_ptr          <= ras_ptr + RAS_PTR_W'(1);
                if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (pop) begin
                ras_ptr <= ras_ptr - RAS_PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

`ifdef PC_CTRL_RAS_STATS_EN
    // Saturating counts of executed returns and of mispredicted returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_cnt      <= 32'd0;
            ret_miss_cnt <= 32'd0;
        end else if (!bus.stall && (bus.npc_sel == SEL_RET)) begin
            if (ret_cnt != 32'hFFFF_FFFF) begin
                ret_cnt <= ret_cnt + 32'd1;
            end
            if (mispred && (ret_miss_cnt != 32'hFFFF_FFFF)) begin
                ret_miss_cnt <= ret_miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios with literal expectations, then random
// flow-control traffic compared every cycle against a queue-based model.
module tb_pc_ctrl;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_ctrl_if #(.ADDR_W(AW)) bus ();

`ifdef PC_CTRL_RAS_STATS_EN
    logic [31:0] ret_cnt;
    logic [31:0] ret_miss_cnt;
`endif

    pc_ctrl #(
        .ADDR_W   (AW),
        .RESET_PC (32'h0000_3000),
        .RAS_DEPTH(4),
        .RAS_PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef PC_CTRL_RAS_STATS_EN
        ,
        .ret_cnt     (ret_cnt),
        .ret_miss_cnt(ret_miss_cnt)
`endif
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic started  = 1'b0;

    // Reference model: PC value, return stack as a bounded queue (newest at back).
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic [31:0] m_ret;
    logic [31:0] m_miss;

    logic [31:0] tops [4] = '{32'h5004, 32'h4C04, 32'h4804, 32'h4404};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic m_cond(input logic [2:0] br, input logic [31:0] rs, input logic [31:0] rt);
        case (br)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return $signed(rs) <= 0;
            3'd3:    return $signed(rs) > 0;
            3'd4:    return $signed(rs) < 0;
            3'd5:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_next();
        case (bus.npc_sel)
            3'd1:    return m_cond(bus.br_type, bus.rs_val, bus.rt_val)
                            ? m_pc + 32'd4 + bus.ext * 32'd4 : m_pc + 32'd4;
            3'd2, 3'd3: return (m_pc & 32'hF000_0000) | (32'(bus.imm26) * 32'd4);
            3'd4, 3'd5, 3'd6: return bus.ra;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] m_top();
        return (m_ras.size() == 0) ? 32'd0 : m_ras[$];
    endfunction

    function automatic logic m_mispred();
        return (bus.npc_sel == 3'd5) && ((m_ras.size() == 0) || (m_ras[$] != bus.ra));
    endfunction

    // Model state update on each clock edge, cleared by reset at any time.
    always @(posedge clk or posedge reset) begin : model_upd
        logic [31:0] nxt;
        if (reset) begin
            m_pc   = 32'h3000;
            m_ras.delete();
            m_ret  = 32'd0;
            m_miss = 32'd0;
        end else if (!bus.stall) begin
            nxt = m_next();
            if (bus.npc_sel == 3'd3 || bus.npc_sel == 3'd6) begin
                if (m_ras.size() == 4) void'(m_ras.pop_front());
                m_ras.push_back(m_pc + 32'd4);
            end else if (bus.npc_sel == 3'd5) begin
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
                if (m_mispred() && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
                if (m_ras.size() != 0) void'(m_ras.pop_back());
            end
            m_pc = nxt;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            check("pc",          bus.pc,  m_pc);
            check("pc4",         bus.pc4, m_pc + 32'd4);
            check("npc",         bus.npc, m_next());
            check("br_taken",    32'(bus.br_taken),
                  32'(bus.npc_sel == 3'd1 && m_cond(bus.br_type, bus.rs_val, bus.rt_val)));
            check("misalign",    32'(bus.misalign), 32'(m_next() % 32'd4 != 32'd0));
            check("ras_top",     bus.ras_top, m_top());
            check("ras_empty",   32'(bus.ras_empty), 32'(m_ras.size() == 0));
            check("ret_mispred", 32'(bus.ret_mispred), 32'(m_mispred()));
`ifdef PC_CTRL_RAS_STATS_EN
            check("ret_cnt",      ret_cnt,      m_ret);
            check("ret_miss_cnt", ret_miss_cnt, m_miss);
`endif
        end
    end

    task automatic idle();
        bus.stall   = 1'b0;
        bus.npc_sel = 3'd0;
        bus.br_type = 3'd0;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        bus.imm26   = 26'd0;
        bus.ext     = 32'd0;
        bus.ra      = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(0, 7));
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] r;
        reset = 1'b0;
        idle();
        #1 reset = 1'b1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and sequential flow.
        check("rst_pc",    bus.pc, 32'h3000);
        check("rst_empty", 32'(bus.ras_empty), 32'd1);
        check("rst_top",   bus.ras_top, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", bus.pc, 32'(32'h3000 + 4 * i));
        end
        tick();

        // Branches at pc=0x3010.
        bus.npc_sel = 3'd1; bus.br_type = 3'd0;
        bus.rs_val = 32'd5; bus.rt_val = 32'd5; bus.ext = 32'hFFFF_FFFE;
        #1;
        check("beq_npc", bus.npc, 32'h300C);
        check("beq_tk",  32'(bus.br_taken), 32'd1);
        bus.rt_val = 32'd6;
        #1;
        check("beq_nt_npc", bus.npc, 32'h3014);
        check("beq_nt_tk",  32'(bus.br_taken), 32'd0);
        bus.br_type = 3'd2; bus.rs_val = 32'h8000_0000;
        #1;
        check("blez_tk", 32'(bus.br_taken), 32'd1);
        tick();
        check("blez_pc", bus.pc, 32'h300C);

        // jal / ret pair.
        idle(); bus.npc_sel = 3'd4; bus.ra = 32'h3000;
        tick();
        check("jr_pc", bus.pc, 32'h3000);
        idle(); bus.npc_sel = 3'd3; bus.imm26 = 26'h0000C10;
        #1;
        check("jal_npc", bus.npc, 32'h3040);
        tick();
        check("jal_pc",  bus.pc, 32'h3040);
        check("jal_top", bus.ras_top, 32'h3004);
        idle(); bus.npc_sel = 3'd5; bus.ra = 32'h3004;
        #1;
        check("ret_ok_mp", 32'(bus.ret_mispred), 32'd0);
        tick();
        check("ret_pc",    bus.pc, 32'h3004);
        check("ret_empty", 32'(bus.ras_empty), 32'd1);

        // Overflow: five pushes into a four-deep stack, then five returns.
        idle(); bus.npc_sel = 3'd4; bus.ra = 32'h4000;
        tick();
        for (int k = 0; k < 5; k++) begin
            idle(); bus.npc_sel = 3'd3; bus.imm26 = 26'(32'h1100 + 32'h100 * k);
            tick();
            check("push_pc", bus.pc, 32'(32'h4400 + 32'h400 * k));
        end
        check("full_top", bus.ras_top, 32'h5004);
        for (int k = 0; k < 4; k++) begin
            idle(); bus.npc_sel = 3'd5; bus.ra = tops[k];
            #1;
            check("pop_top", bus.ras_top, tops[k]);
            check("pop_mp",  32'(bus.ret_mispred), 32'd0);
            tick();
            check("pop_pc",  bus.pc, tops[k]);
        end
        check("drained", 32'(bus.ras_empty), 32'd1);
        idle(); bus.npc_sel = 3'd5; bus.ra = 32'h4004;
        #1;
        check("empty_ret_mp", 32'(bus.ret_mispred), 32'd1);
        tick();
        check("empty_ret_pc",    bus.pc, 32'h4004);
        check("empty_ret_empty", 32'(bus.ras_empty), 32'd1);

        // Stalled jal has no effect until released.
        idle(); bus.npc_sel = 3'd3; bus.imm26 = 26'h0001800; bus.stall = 1'b1;
        tick();
        check("stall_pc",    bus.pc, 32'h4004);
        check("stall_empty", 32'(bus.ras_empty), 32'd1);
        bus.stall = 1'b0;
        tick();
        check("unstall_pc",  bus.pc, 32'h6000);
        check("unstall_top", bus.ras_top, 32'h4008);
        idle();
        tick();
        check("once_top", bus.ras_top, 32'h4008);
        check("once_pc",  bus.pc, 32'h6004);

        // Misaligned register target loads anyway.
        idle(); bus.npc_sel = 3'd4; bus.ra = 32'h3002;
        #1;
        check("misalign", 32'(bus.misalign), 32'd1);
        tick();
        check("misalign_pc", bus.pc, 32'h3002);

        // Mid-cycle reset clears immediately.
        idle();
        reset = 1'b1;
        #2;
        check("async_pc",    bus.pc, 32'h3000);
        check("async_empty", 32'(bus.ras_empty), 32'd1);
        reset = 1'b0;
        bus.npc_sel = 3'd3; bus.imm26 = 26'h0000C10;
        tick();
        idle(); bus.npc_sel = 3'd5; bus.ra = 32'h3004;
        tick();
        idle(); bus.npc_sel = 3'd5; bus.ra = 32'h1234_5678;
        tick();
        check("miss_pc", bus.pc, 32'h1234_5678);
`ifdef PC_CTRL_RAS_STATS_EN
        check("stats_ret",  ret_cnt, 32'd2);
        check("stats_miss", ret_miss_cnt, 32'd1);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            bus.npc_sel = 3'($urandom_range(0, 7));
            bus.br_type = 3'($urandom_range(0, 7));
            bus.rs_val  = pick();
            bus.rt_val  = ($urandom_range(0, 3) == 0) ? bus.rs_val : pick();
            bus.imm26   = 26'($urandom);
            bus.ext     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255))
                                                      : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
            r = 32'($urandom);
            if ($urandom_range(0, 2) != 0 && m_ras.size() != 0) bus.ra = m_ras[$];
            else if ($urandom_range(0, 7) == 0) bus.ra = r;
            else bus.ra = r & 32'hFFFF_FFFC;
            bus.stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
